// File: rtl/btb_pkg.sv
// Shared types and width helpers for the set-associative branch target buffer.
package btb_pkg;

  // Widest tag occurs at the smallest legal table (16 sets -> 26 bits).
  localparam int unsigned TagMaxW = 26;

  function automatic int unsigned idx_w(input int unsigned sets);
    return $clog2(sets);
  endfunction

  function automatic int unsigned tag_w(input int unsigned sets);
    return 30 - $clog2(sets);
  endfunction

  typedef struct packed {
    logic               valid;
    logic [TagMaxW-1:0] tag;
    logic [31:0]        target;
  } btb_entry_t;

  typedef enum logic {
    StIdle  = 1'b0,
    StSweep = 1'b1
  } btb_state_e;

endpackage

// File: rtl/btb_plru.sv
// Combinational tree-PLRU helper: next-state bits for an access and the current victim way.
module btb_plru #(
  parameter int unsigned WAYS = 2,
  localparam int unsigned PW = (WAYS > 1) ? WAYS - 1 : 1,
  localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [PW-1:0] i_bits,
  input  logic [WW-1:0] i_way,
  output logic [PW-1:0] o_bits,
  output logic [WW-1:0] o_victim
);

  if (WAYS == 1) begin : g_direct
    logic w_unused;
    assign w_unused = ^{i_bits, i_way};
    assign o_bits   = '0;
    assign o_victim = '0;
  end else begin : g_tree
    // Heap-ordered nodes: children of n are 2n+1 (left) and 2n+2 (right); a bit points at the LRU side.
    always_comb begin
      logic [WW-1:0] w_n;
      o_bits = i_bits;
      w_n    = '0;
      for (int l = 0; l < int'(WW); l++) begin
        o_bits[w_n] = ~i_way[WW-1-l];
        w_n = WW'(2 * int'(w_n) + 1 + int'(i_way[WW-1-l]));
      end
    end

    always_comb begin
      logic [WW-1:0] w_m;
      o_victim = '0;
      w_m      = '0;
      for (int l = 0; l < int'(WW); l++) begin
        o_victim[WW-1-l] = i_bits[w_m];
        w_m = WW'(2 * int'(w_m) + 1 + int'(i_bits[w_m]));
      end
    end
  end

endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB with registered lookup, tree-PLRU replacement and a one-set-per-cycle flush sweep.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int unsigned SETS        = 512,
  parameter int unsigned WAYS        = 2,
  parameter bit          INVAL_ON_NT = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        STALL,
  input  logic [31:0] Instr_PC_IN_IF,
  input  logic [31:0] Instr_PC_IN_ID,
  input  logic        is_Branch_IN_ID,
  input  logic        is_Taken_IN_ID,
  input  logic [31:0] Alt_PC_IN_ID,
  input  logic        FLUSH,
  output logic        flush_busy_BTB,
  output logic        hit_BTB,
  output logic [31:0] take_Alt_PC_OUT_IF
);

  localparam int unsigned IW = idx_w(SETS);
  localparam int unsigned TW = tag_w(SETS);
  localparam int unsigned PW = (WAYS > 1) ? WAYS - 1 : 1;
  localparam int unsigned WW = (WAYS > 1) ? $clog2(WAYS) : 1;

  btb_state_e    r_state;
  logic [IW-1:0] r_cnt;
  logic          r_hit;
  logic [31:0]   r_tgt;

  logic [WAYS-1:0] r_valid  [SETS];
  logic [PW-1:0]   r_plru   [SETS];
  logic [TW-1:0]   r_tag    [SETS][WAYS];
  logic [31:0]     r_target [SETS][WAYS];

  logic [IW-1:0] w_idx_if, w_idx_id;
  logic [TW-1:0] w_tag_if, w_tag_id;
  logic          w_unused_lsb;

  assign w_idx_if     = Instr_PC_IN_IF[IW+1:2];
  assign w_tag_if     = Instr_PC_IN_IF[31:IW+2];
  assign w_idx_id     = Instr_PC_IN_ID[IW+1:2];
  assign w_tag_id     = Instr_PC_IN_ID[31:IW+2];
  assign w_unused_lsb = ^{Instr_PC_IN_IF[1:0], Instr_PC_IN_ID[1:0]};

  btb_entry_t w_ent_if [WAYS];
  btb_entry_t w_ent_id [WAYS];

  always_comb begin
    for (int w = 0; w < int'(WAYS); w++) begin
      w_ent_if[w] = '{valid: r_valid[w_idx_if][w], tag: TagMaxW'(r_tag[w_idx_if][w]),
                      target: r_target[w_idx_if][w]};
      w_ent_id[w] = '{valid: r_valid[w_idx_id][w], tag: TagMaxW'(r_tag[w_idx_id][w]),
                      target: r_target[w_idx_id][w]};
    end
  end

  // Lookup: at most one way matches, so OR-ing targets acts as the mux.
  logic        w_hit_if;
  logic [31:0] w_tgt_if;

  always_comb begin
    w_hit_if = 1'b0;
    w_tgt_if = '0;
    for (int w = 0; w < int'(WAYS); w++) begin
      if (w_ent_if[w].valid && w_ent_if[w].tag == TagMaxW'(w_tag_if)) begin
        w_hit_if = 1'b1;
        w_tgt_if = w_tgt_if | w_ent_if[w].target;
      end
    end
    w_hit_if = w_hit_if && (Instr_PC_IN_IF != 32'd0) && (r_state == StIdle);
  end

  logic          w_upd_hit, w_inv_any;
  logic [WW-1:0] w_hit_idx, w_inv_idx, w_victim, w_alloc_way, w_acc_way;
  logic [PW-1:0] w_plru_nxt, w_unused_bits;
  logic [WW-1:0] w_unused_victim;
  logic          w_upd_en;

  always_comb begin
    w_upd_hit = 1'b0;
    w_hit_idx = '0;
    w_inv_any = 1'b0;
    w_inv_idx = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (w_ent_id[w].valid && w_ent_id[w].tag == TagMaxW'(w_tag_id)) begin
        w_upd_hit = 1'b1;
        w_hit_idx = WW'(w);
      end
      if (!w_ent_id[w].valid) begin
        w_inv_any = 1'b1;
        w_inv_idx = WW'(w);
      end
    end
  end

  assign w_alloc_way = w_inv_any ? w_inv_idx : w_victim;
  assign w_acc_way   = w_upd_hit ? w_hit_idx : w_alloc_way;
  assign w_upd_en    = !STALL && is_Branch_IN_ID && (Instr_PC_IN_ID != 32'd0) &&
                       (r_state == StIdle);

  btb_plru #(.WAYS(WAYS)) u_plru_upd (
    .i_bits   (r_plru[w_idx_id]),
    .i_way    (w_acc_way),
    .o_bits   (w_plru_nxt),
    .o_victim (w_unused_victim)
  );

  btb_plru #(.WAYS(WAYS)) u_plru_vic (
    .i_bits   (r_plru[w_idx_id]),
    .i_way    ('0),
    .o_bits   (w_unused_bits),
    .o_victim (w_victim)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
      r_tgt   <= '0;
      for (int s = 0; s < int'(SETS); s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if (!STALL) begin
        r_hit <= w_hit_if;
        r_tgt <= w_hit_if ? w_tgt_if : Instr_PC_IN_IF + 32'd4;
      end
      unique case (r_state)
        StIdle: begin
          if (FLUSH) begin
            r_state <= StSweep;
            r_cnt   <= '0;
          end
        end
        StSweep: begin
          r_valid[r_cnt] <= '0;
          r_plru[r_cnt]  <= '0;
          r_cnt          <= r_cnt + 1'b1;
          if (r_cnt == IW'(SETS - 1)) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
      if (w_upd_en) begin
        if (is_Taken_IN_ID) begin
          if (!w_upd_hit) r_valid[w_idx_id][w_alloc_way] <= 1'b1;
          r_plru[w_idx_id] <= w_plru_nxt;
        end else if (w_upd_hit) begin
          if (INVAL_ON_NT) r_valid[w_idx_id][w_hit_idx] <= 1'b0;
          else             r_plru[w_idx_id]             <= w_plru_nxt;
        end
      end
    end
  end

  // Tag and target are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge CLK) begin
    if (w_upd_en && is_Taken_IN_ID) begin
      if (w_upd_hit) begin
        r_target[w_idx_id][w_hit_idx] <= Alt_PC_IN_ID;
      end else begin
        r_tag[w_idx_id][w_alloc_way]    <= w_tag_id;
        r_target[w_idx_id][w_alloc_way] <= Alt_PC_IN_ID;
      end
    end
  end

  assign flush_busy_BTB     = (r_state == StSweep);
  assign hit_BTB            = r_hit;
  assign take_Alt_PC_OUT_IF = r_tgt;

endmodule

// File: tb/tb_btb_assoc.sv
// Self-checking bench for btb_assoc (16 sets, 2 ways): vector table with scoreboard plus flush/stall/reset sequences.
module tb_btb_assoc;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        STALL = 1'b0;
  logic [31:0] Instr_PC_IN_IF = '0;
  logic [31:0] Instr_PC_IN_ID = '0;
  logic        is_Branch_IN_ID = 1'b0;
  logic        is_Taken_IN_ID = 1'b0;
  logic [31:0] Alt_PC_IN_ID = '0;
  logic        FLUSH = 1'b0;
  logic        flush_busy_BTB;
  logic        hit_BTB;
  logic [31:0] take_Alt_PC_OUT_IF;

  btb_assoc #(.SETS(16), .WAYS(2), .INVAL_ON_NT(1'b0)) dut (
    .CLK                (CLK),
    .RESET              (RESET),
    .STALL              (STALL),
    .Instr_PC_IN_IF     (Instr_PC_IN_IF),
    .Instr_PC_IN_ID     (Instr_PC_IN_ID),
    .is_Branch_IN_ID    (is_Branch_IN_ID),
    .is_Taken_IN_ID     (is_Taken_IN_ID),
    .Alt_PC_IN_ID       (Alt_PC_IN_ID),
    .FLUSH              (FLUSH),
    .flush_busy_BTB     (flush_busy_BTB),
    .hit_BTB            (hit_BTB),
    .take_Alt_PC_OUT_IF (take_Alt_PC_OUT_IF)
  );

  always #5 CLK = ~CLK;

  localparam logic [31:0] PcA = 32'h0040_0010;
  localparam logic [31:0] PcB = 32'h0040_0810;
  localparam logic [31:0] PcC = 32'h0040_1010;
  localparam logic [31:0] PcD = 32'h0040_0024;
  localparam logic [31:0] PcE = 32'h0040_0030;
  localparam logic [31:0] PcF = 32'h0040_0044;
  localparam logic [31:0] PcG = 32'h0040_0064;

  typedef struct {
    logic [31:0] pc_if;
    logic        br;
    logic        tk;
    logic [31:0] pc_id;
    logic [31:0] alt;
    logic        exp_hit;
    logic [31:0] exp_tgt;
  } vec_t;

  typedef struct {
    logic        hit;
    logic [31:0] tgt;
    string       name;
  } exp_t;

  vec_t vecs[21];
  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic drive(input logic [31:0] pc_if, input logic br, input logic tk,
                       input logic [31:0] pc_id, input logic [31:0] alt);
    Instr_PC_IN_IF  = pc_if;
    is_Branch_IN_ID = br;
    is_Taken_IN_ID  = tk;
    Instr_PC_IN_ID  = pc_id;
    Alt_PC_IN_ID    = alt;
  endtask

  // Drive one cycle, queue its expected result, and compare the output after the edge.
  task automatic cycle(input string name, input logic [31:0] pc_if, input logic br,
                       input logic tk, input logic [31:0] pc_id, input logic [31:0] alt,
                       input logic exp_hit, input logic [31:0] exp_tgt);
    exp_t e;
    drive(pc_if, br, tk, pc_id, alt);
    sb.push_back('{hit: exp_hit, tgt: exp_tgt, name: name});
    @(posedge CLK);
    #1;
    e = sb.pop_front();
    chk({e.name, "_hit"}, 32'(hit_BTB), 32'(e.hit));
    chk({e.name, "_tgt"}, take_Alt_PC_OUT_IF, e.tgt);
  endtask

  initial begin
    int n;

    vecs[0]  = '{PcA,         0, 0, 32'd0, 32'd0,         0, 32'h0040_0014};
    vecs[1]  = '{32'd0,       1, 1, PcA,   32'h0040_0100, 0, 32'h0000_0004};
    vecs[2]  = '{PcA,         0, 0, 32'd0, 32'd0,         1, 32'h0040_0100};
    vecs[3]  = '{PcB,         1, 1, PcB,   32'h0040_0200, 0, 32'h0040_0814};
    vecs[4]  = '{PcB,         1, 1, PcA,   32'h0040_0100, 1, 32'h0040_0200};
    vecs[5]  = '{PcA,         1, 1, PcC,   32'h0040_0300, 1, 32'h0040_0100};
    vecs[6]  = '{PcB,         0, 0, 32'd0, 32'd0,         0, 32'h0040_0814};
    vecs[7]  = '{PcC,         0, 0, 32'd0, 32'd0,         1, 32'h0040_0300};
    vecs[8]  = '{PcA,         0, 0, 32'd0, 32'd0,         1, 32'h0040_0100};
    vecs[9]  = '{PcC,         1, 0, PcC,   32'h0000_0000, 1, 32'h0040_0300};
    vecs[10] = '{PcC,         1, 1, PcD,   32'h0040_0400, 1, 32'h0040_0300};
    vecs[11] = '{PcD,         0, 0, 32'd0, 32'd0,         1, 32'h0040_0400};
    vecs[12] = '{32'h0040_0013, 0, 1, PcE, 32'h0040_0999, 1, 32'h0040_0100};
    vecs[13] = '{PcE,         0, 0, 32'd0, 32'd0,         0, 32'h0040_0034};
    vecs[14] = '{PcA,         1, 1, PcA,   32'h0040_0500, 1, 32'h0040_0100};
    vecs[15] = '{PcA,         0, 0, 32'd0, 32'd0,         1, 32'h0040_0500};
    vecs[16] = '{32'h0040_0813, 1, 0, PcC, 32'h0000_0000, 0, 32'h0040_0817};
    vecs[17] = '{PcA,         1, 1, PcB,   32'h0040_0200, 1, 32'h0040_0500};
    vecs[18] = '{PcA,         0, 0, 32'd0, 32'd0,         0, 32'h0040_0014};
    vecs[19] = '{PcC,         0, 0, 32'd0, 32'd0,         1, 32'h0040_0300};
    vecs[20] = '{PcB,         0, 0, 32'd0, 32'd0,         1, 32'h0040_0200};

    #2 RESET = 1'b0;
    #2;
    chk("reset_hit", 32'(hit_BTB), 32'd0);
    chk("reset_tgt", take_Alt_PC_OUT_IF, 32'd0);
    chk("reset_busy", 32'(flush_busy_BTB), 32'd0);
    #8 RESET = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 0; i < 21; i++)
      cycle($sformatf("vec%0d", i), vecs[i].pc_if, vecs[i].br, vecs[i].tk, vecs[i].pc_id,
            vecs[i].alt, vecs[i].exp_hit, vecs[i].exp_tgt);

    // Stall: outputs frozen at the last result, and the presented update is dropped.
    STALL = 1'b1;
    cycle("stall0", PcC, 1, 1, PcF, 32'h0040_0600, 1, 32'h0040_0200);
    cycle("stall1", PcD, 1, 1, PcF, 32'h0040_0600, 1, 32'h0040_0200);
    cycle("stall2", 32'h1234_5678, 1, 1, PcF, 32'h0040_0600, 1, 32'h0040_0200);
    STALL = 1'b0;
    cycle("post_stall_f", PcF, 0, 0, 32'd0, 32'd0, 0, 32'h0040_0048);

    // Flush sweep: lookups forced to miss, updates lost, re-FLUSH ignored.
    FLUSH = 1'b1;
    cycle("flush_req", PcB, 0, 0, 32'd0, 32'd0, 1, 32'h0040_0200);
    chk("flush_busy_start", 32'(flush_busy_BTB), 32'd1);
    FLUSH = 1'b0;
    drive(PcB, 1, 1, PcG, 32'h0040_0700);
    n = 0;
    while (flush_busy_BTB && n < 100) begin
      FLUSH = (n == 5);
      @(posedge CLK);
      #1;
      n++;
      if (n == 1) begin
        chk("sweep_hit", 32'(hit_BTB), 32'd0);
        chk("sweep_tgt", take_Alt_PC_OUT_IF, 32'h0040_0814);
      end
    end
    FLUSH = 1'b0;
    chk("flush_busy_cycles", n, 16);
    cycle("post_flush_b", PcB, 0, 0, 32'd0, 32'd0, 0, 32'h0040_0814);
    cycle("post_flush_c", PcC, 0, 0, 32'd0, 32'd0, 0, 32'h0040_1014);
    cycle("post_flush_d", PcD, 0, 0, 32'd0, 32'd0, 0, 32'h0040_0028);
    cycle("post_flush_g", PcG, 0, 0, 32'd0, 32'd0, 0, 32'h0040_0068);

    // Refill, then reset in the middle of a sweep.
    cycle("refill_a", PcC, 1, 1, PcA, 32'h0040_0100, 0, 32'h0040_1014);
    FLUSH = 1'b1;
    cycle("flush2_req", PcA, 0, 0, 32'd0, 32'd0, 1, 32'h0040_0100);
    FLUSH = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge CLK);
      #1;
    end
    chk("mid_sweep_busy", 32'(flush_busy_BTB), 32'd1);
    #2 RESET = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(flush_busy_BTB), 32'd0);
    chk("rst_mid_hit", 32'(hit_BTB), 32'd0);
    chk("rst_mid_tgt", take_Alt_PC_OUT_IF, 32'd0);
    #2 RESET = 1'b1;
    @(posedge CLK);
    #1;
    cycle("after_rst_upd", PcC, 1, 1, PcA, 32'h0040_0100, 0, 32'h0040_1014);
    cycle("after_rst_a", PcA, 0, 0, 32'd0, 32'd0, 1, 32'h0040_0100);
    cycle("after_rst_busy_idle", PcB, 0, 0, 32'd0, 32'd0, 0, 32'h0040_0814);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/btb_assoc.md
BTB_ASSOC -- requirements
Module: btb_assoc

Interface
REQ-001 SHALL have parameter SETS, default 512, meaning number of sets; power of two, 16..1024.
REQ-002 SHALL have parameter WAYS, default 2, meaning associativity; power of two, 1..8.
REQ-003 SHALL have parameter INVAL_ON_NT, default 0, meaning a not-taken hit clears that entry when set to 1.
REQ-004 SHALL have port CLK, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-005 SHALL have port RESET, input, 1, meaning the reset, which is asynchronous and active-low.
REQ-006 SHALL have port STALL, input, 1, meaning pipeline stall; holds outputs and blocks updates.
REQ-007 SHALL have port Instr_PC_IN_IF, input, 32, meaning the fetch PC to look up.
REQ-008 SHALL have ports Instr_PC_IN_ID (input, 32), is_Branch_IN_ID (1), is_Taken_IN_ID (1) and Alt_PC_IN_ID (32), meaning the resolved-branch update from ID.
REQ-009 SHALL have port FLUSH, input, 1, meaning a single-cycle request to invalidate all entries.
REQ-010 SHALL have port flush_busy_BTB, output, 1, meaning a flush sweep is in progress.
REQ-011 SHALL have ports hit_BTB (output, 1) and take_Alt_PC_OUT_IF (output, 32), meaning the registered lookup result.

Function
REQ-012 SHALL form the index as PC[IW+1:2] and the tag as PC[31:IW+2], where IW = log2(SETS); bits 1:0 are ignored.
REQ-013 SHALL store, per set and way, a valid bit, a tag and a 32-bit target, plus WAYS-1 tree-PLRU bits per set (none when WAYS=1).
REQ-014 SHALL define a lookup hit as any way in the indexed set with valid=1 and a matching tag, with Instr_PC_IN_IF != 0; at most one way can match.
REQ-015 SHALL, on each rising CLK edge with STALL=0, register hit_BTB = hit and take_Alt_PC_OUT_IF = (hit ? stored target : Instr_PC_IN_IF+4), giving 1-cycle latency.
REQ-016 SHALL, when STALL=1, hold both outputs unchanged.
REQ-017 SHALL perform an update on the rising edge when STALL=0, is_Branch_IN_ID=1, Instr_PC_IN_ID != 0 and the FSM is IDLE; otherwise no table state changes.
REQ-018 SHALL, on a taken update that hits, overwrite the hit way's target with Alt_PC_IN_ID and mark that way MRU.
REQ-019 SHALL, on a taken update that misses, allocate the lowest-index invalid way, else the PLRU victim; it writes valid=1, the tag and the target, and marks the way MRU.
REQ-020 SHALL, on a not-taken update that hits, clear that way's valid bit if INVAL_ON_NT=1, else only mark it MRU; a not-taken miss is a no-op.
REQ-021 SHALL, when a lookup and an update address the same set in one cycle, base the lookup on pre-update contents (no bypass).
REQ-022 SHALL implement a two-state FSM, IDLE and SWEEP, with an index counter of IW bits.
REQ-023 SHALL, when FLUSH=1 in IDLE, enter SWEEP with counter=0 on the next edge, regardless of STALL.
REQ-024 SHALL, in SWEEP, clear all valid bits and PLRU bits of set[counter] each cycle and increment the counter; after set SETS-1 it returns to IDLE (exactly SETS cycles).
REQ-025 SHALL, in SWEEP, keep flush_busy_BTB=1, force lookup hits to 0 and drop updates; FLUSH asserted during SWEEP is ignored.

Reset
REQ-026 SHALL, on RESET low, immediately set hit_BTB=0, take_Alt_PC_OUT_IF=0, flush_busy_BTB=0, FSM=IDLE, counter=0, all valid bits=0 and all PLRU bits=0.
REQ-027 SHALL leave tag and target arrays unreset; they are unobservable while invalid.
REQ-028 SHALL abort a sweep when reset occurs mid-sweep, returning to IDLE with all entries invalid.

Structure
REQ-029 SHALL place in shared package btb_pkg: the index/tag width functions, the entry struct {valid, tag, target} and the FSM state enum.
REQ-030 SHALL use sub-module btb_plru, a combinational block that takes the current PLRU bits and the accessed way and produces the next PLRU bits and the victim way; it is instantiated twice (lookup is read-only, so once for update and once for victim).

Verification
REQ-031 SHALL cover: reset, then lookup 0x00400010 -> next cycle hit_BTB=0, take_Alt_PC_OUT_IF=0x00400014.
REQ-032 SHALL cover: taken update PC 0x00400010, target 0x00400100, then lookup 0x00400010 -> hit_BTB=1, target 0x00400100; lookup 0x00400810 (same set, other tag) -> miss.
REQ-033 SHALL cover, with WAYS=2: taken updates A=0x00400010, B=0x00400810, touch A, then C=0x00401010 -> B evicted, A and C hit.
REQ-034 SHALL cover: update and lookup of the same new PC in one cycle -> that lookup misses, the next lookup hits.
REQ-035 SHALL cover: FLUSH with SETS=16 -> flush_busy_BTB high exactly 16 cycles, updates during the sweep are lost, all prior entries then miss.
REQ-036 SHALL cover: STALL=1 for 3 cycles with changing Instr_PC_IN_IF -> outputs frozen; a taken update presented during the stall is not written.
